d_cache_nway: RTL and testbench

D_CACHE_NWAY -- requirements
Module: d_cache_nway

---
 rtl/d_cache_nway_pkg.sv | 30 +++
 rtl/d_cache_lru.sv | 55 +++++
 rtl/d_cache_nway.sv | 174 +++++++++++++++++
 tb/tb_d_cache_nway.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_nway_pkg.sv
// Shared constants, state encoding and address-field width helpers for the
// n-way write-back data cache.
package d_cache_nway_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned PADDR_W        = 30;
  localparam int unsigned LADDR_W        = 28;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WRITE_BACK = 3'd1;
  localparam logic [2:0] ST_ALLOCATE   = 3'd2;
  localparam logic [2:0] ST_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] ST_FLUSH_WB   = 3'd4;

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned sets);
    return LADDR_W - $clog2(sets);
  endfunction

  // A direct-mapped cache still needs a 1-bit way/rank field to keep vectors legal.
  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/d_cache_lru.sv
// Per-set LRU rank storage (0 = most recent), hit update and victim selection.
module d_cache_lru
  import d_cache_nway_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 4,
  localparam int unsigned IDX_W = idx_width(SETS),
  localparam int unsigned WAY_W = way_width(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] look_set,
  input  logic [WAYS-1:0]  look_valid,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] rank [SETS][WAYS];
  logic             found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          rank[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          rank[touch_set][w] <= '0;
        else if (rank[touch_set][w] < rank[touch_set][touch_way])
          rank[touch_set][w] <= rank[touch_set][w] + 1'b1;
      end
    end
  end

  // Invalid ways win over the LRU choice, lowest index first.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !look_valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++)
        if (rank[look_set][w] == WAY_W'(WAYS - 1))
          victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/d_cache_nway.sv
// N-way set-associative write-back, write-allocate data cache with LRU
// replacement and a full-cache flush sequencer.
module d_cache_nway
  import d_cache_nway_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 4
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  input  logic         proc_flush,
  output logic         proc_flush_done,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned IDX_W = idx_width(SETS);
  localparam int unsigned TAG_W = tag_width(SETS);
  localparam int unsigned WAY_W = way_width(WAYS);

  logic [2:0]        state;
  logic [WAY_W-1:0]  vic_way, fl_way, hit_way, lru_victim, wb_way;
  logic [IDX_W-1:0]  fl_set, idx, wb_set;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        wsel;
  logic              req, hit, fl_last, fl_dirty, fl_step, done_q;
  logic [LINE_W-1:0] hit_line;

  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem [SETS][WAYS];

  assign req     = proc_read | proc_write;
  assign idx     = proc_addr[IDX_W+1:2];
  assign req_tag = proc_addr[29:IDX_W+2];
  assign wsel    = proc_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tag_mem[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line        = data_mem[idx][hit_way];
  assign proc_rdata      = (state == ST_IDLE && hit) ? hit_line[{wsel, 5'b0} +: WORD_W] : '0;
  assign proc_stall      = proc_reset_n && ((state != ST_IDLE) || (req && !hit));
  assign proc_flush_done = done_q;

  assign fl_last  = (fl_way == WAY_W'(WAYS - 1)) && (fl_set == IDX_W'(SETS - 1));
  assign fl_dirty = valid[fl_set][fl_way] && dirty[fl_set][fl_way];
  assign fl_step  = (state == ST_FLUSH_SCAN && !fl_dirty) || (state == ST_FLUSH_WB && mem_ready);
  assign wb_set   = (state == ST_FLUSH_WB) ? fl_set : idx;
  assign wb_way   = (state == ST_FLUSH_WB) ? fl_way : vic_way;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_WRITE_BACK, ST_FLUSH_WB: begin
        mem_write = 1'b1;
        mem_addr  = {tag_mem[wb_set][wb_way], wb_set};
        mem_wdata = data_mem[wb_set][wb_way];
      end
      ST_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, idx};
      end
      default: ;
    endcase
  end

  d_cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk        (clk),
    .rst_n      (proc_reset_n),
    .touch      (state == ST_IDLE && req && hit),
    .touch_set  (idx),
    .touch_way  (hit_way),
    .look_set   (idx),
    .look_valid (valid[idx]),
    .victim     (lru_victim)
  );

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state   <= ST_IDLE;
      vic_way <= '0;
      fl_set  <= '0;
      fl_way  <= '0;
      done_q  <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              if (proc_write) dirty[idx][hit_way] <= 1'b1;
            end else begin
              vic_way <= lru_victim;
              state   <= (valid[idx][lru_victim] && dirty[idx][lru_victim]) ? ST_WRITE_BACK
                                                                              : ST_ALLOCATE;
            end
          end else if (proc_flush) begin
            state  <= ST_FLUSH_SCAN;
            fl_set <= '0;
            fl_way <= '0;
          end
        end
        ST_WRITE_BACK: begin
          if (mem_ready) begin
            dirty[idx][vic_way] <= 1'b0;
            state               <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            valid[idx][vic_way] <= 1'b1;
            dirty[idx][vic_way] <= 1'b0;
            state               <= ST_IDLE;
          end
        end
        ST_FLUSH_SCAN: if (fl_dirty) state <= ST_FLUSH_WB;
        ST_FLUSH_WB:   if (mem_ready) dirty[fl_set][fl_way] <= 1'b0;
        default:       state <= ST_IDLE;
      endcase
      // Pointer advance shared by a clean scan slot and a finished flush write-back.
      if (fl_step) begin
        if (fl_last) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end else if (fl_way == WAY_W'(WAYS - 1)) begin
          fl_way <= '0;
          fl_set <= fl_set + 1'b1;
          state  <= ST_FLUSH_SCAN;
        end else begin
          fl_way <= fl_way + 1'b1;
          state  <= ST_FLUSH_SCAN;
        end
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && proc_write && hit)
      data_mem[idx][hit_way][{wsel, 5'b0} +: WORD_W] <= proc_wdata;
    if (state == ST_ALLOCATE && mem_ready) begin
      data_mem[idx][vic_way] <= mem_rdata;
      tag_mem[idx][vic_way]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_d_cache_nway.sv
// Directed checks on the default 2-way/4-set cache plus a randomised
// reference-model run on a 4-way/2-set instance.
module tb_d_cache_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] dword(input logic [29:0] wa);
    return {wa[29:2], 2'b00, wa[1:0]};
  endfunction

  function automatic logic [127:0] dline(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = dword({la, 2'(k)});
    return l;
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] l, input int k, input logic [31:0] w);
    logic [127:0] r;
    r = l;
    r[32*k +: 32] = w;
    return r;
  endfunction

  // ---------------- DUT A: default parameters ----------------
  logic         rst_n = 1'b0;
  logic         p_rd = 1'b0, p_wr = 1'b0, p_flush = 1'b0;
  logic [29:0]  p_addr = '0;
  logic [31:0]  p_wdata = '0;
  logic [31:0]  p_rdata;
  logic         p_stall, p_done;
  logic         m_rd, m_wr;
  logic [27:0]  m_addr;
  logic [127:0] m_wdata;
  logic [127:0] m_rdata = '0;
  logic         m_ready = 1'b0;

  d_cache_nway u_dut (
    .clk(clk), .proc_reset_n(rst_n), .proc_read(p_rd), .proc_write(p_wr),
    .proc_addr(p_addr), .proc_wdata(p_wdata), .proc_rdata(p_rdata), .proc_stall(p_stall),
    .proc_flush(p_flush), .proc_flush_done(p_done), .mem_read(m_rd), .mem_write(m_wr),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata), .mem_ready(m_ready)
  );

  logic [127:0] mem_a [logic [27:0]];
  int lat_a = 3, cnt_a = 0, rd_cnt = 0, wr_cnt = 0, seq = 0, wr_seq = 0, rd_seq = 0, both_err = 0;
  logic [27:0]  wq_addr [$];
  logic [127:0] wq_data [$];

  always @(negedge clk) begin
    if (m_rd && m_wr) both_err++;
    if (m_ready) begin
      m_ready = 1'b0;
      cnt_a   = 0;
    end else if (m_rd || m_wr) begin
      if (cnt_a >= lat_a) begin
        m_ready = 1'b1;
        seq++;
        if (m_wr) begin
          mem_a[m_addr] = m_wdata;
          wq_addr.push_back(m_addr);
          wq_data.push_back(m_wdata);
          wr_cnt++;
          wr_seq = seq;
        end else begin
          m_rdata = mem_a.exists(m_addr) ? mem_a[m_addr] : dline(m_addr);
          rd_cnt++;
          rd_seq = seq;
        end
      end else cnt_a++;
    end else cnt_a = 0;
  end

  task automatic access_a(input logic is_wr, input logic [29:0] a, input logic [31:0] d,
                          output logic [31:0] q, output int cyc);
    p_addr = a; p_wdata = d; p_rd = !is_wr; p_wr = is_wr; cyc = 0;
    #1;
    while (p_stall && cyc < 200) begin tick(); cyc++; end
    if (p_stall) check("access_a_timeout", 128'(1), 128'(0));
    q = p_rdata;
    tick();
    p_rd = 1'b0; p_wr = 1'b0;
  endtask

  // ---------------- DUT B: 4 ways, 2 sets ----------------
  logic         rst2_n = 1'b0;
  logic         b_rd = 1'b0, b_wr = 1'b0, b_flush = 1'b0;
  logic [29:0]  b_addr = '0;
  logic [31:0]  b_wdata = '0;
  logic [31:0]  b_rdata;
  logic         b_stall, b_done;
  logic         bm_rd, bm_wr;
  logic [27:0]  bm_addr;
  logic [127:0] bm_wdata;
  logic [127:0] bm_rdata = '0;
  logic         bm_ready = 1'b0;

  d_cache_nway #(.WAYS(4), .SETS(2)) u_dut_w4 (
    .clk(clk), .proc_reset_n(rst2_n), .proc_read(b_rd), .proc_write(b_wr),
    .proc_addr(b_addr), .proc_wdata(b_wdata), .proc_rdata(b_rdata), .proc_stall(b_stall),
    .proc_flush(b_flush), .proc_flush_done(b_done), .mem_read(bm_rd), .mem_write(bm_wr),
    .mem_addr(bm_addr), .mem_wdata(bm_wdata), .mem_rdata(bm_rdata), .mem_ready(bm_ready)
  );

  logic [127:0] mem_b [logic [27:0]];
  logic [31:0]  ref_mem [logic [29:0]];
  int lat_b = 1, cnt_b = 0;

  always @(negedge clk) begin
    if (bm_rd && bm_wr) both_err++;
    if (bm_ready) begin
      bm_ready = 1'b0;
      cnt_b    = 0;
    end else if (bm_rd || bm_wr) begin
      if (cnt_b >= lat_b) begin
        bm_ready = 1'b1;
        if (bm_wr) mem_b[bm_addr] = bm_wdata;
        else       bm_rdata = mem_b.exists(bm_addr) ? mem_b[bm_addr] : dline(bm_addr);
      end else cnt_b++;
    end else cnt_b = 0;
  end

  task automatic access_b(input logic is_wr, input logic [29:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int cyc;
    b_addr = a; b_wdata = d; b_rd = !is_wr; b_wr = is_wr; cyc = 0;
    #1;
    while (b_stall && cyc < 200) begin tick(); cyc++; end
    if (b_stall) check("access_b_timeout", 128'(1), 128'(0));
    q = b_rdata;
    tick();
    b_rd = 1'b0; b_wr = 1'b0;
  endtask

  function automatic logic [31:0] ref_val(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dword(a);
  endfunction

  function automatic logic [29:0] rand_addr();
    logic [29:0] a;
    a = 30'($urandom_range(0, 47));
    if ($urandom_range(0, 1) == 1) a[29] = 1'b1;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int cyc, n, wr0, rd0, pulses;
    logic [29:0] a;
    logic [31:0] d;

    mem_a[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};

    // Reset: outputs quiet even with a request pending
    p_rd = 1'b1; p_addr = 30'h10;
    repeat (3) tick();
    check("rst_stall", 128'(p_stall), 128'(0));
    check("rst_mem_rd_wr", 128'({m_rd, m_wr}), 128'(0));
    check("rst_mem_addr", 128'(m_addr), 128'(0));
    check("rst_rdata", 128'(p_rdata), 128'(0));
    check("rst_flush_done", 128'(p_done), 128'(0));
    p_rd = 1'b0;
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();

    // Clean read miss of 0x10
    p_addr = 30'h10; p_rd = 1'b1;
    #1;
    check("miss_stall", 128'(p_stall), 128'(1));
    check("miss_cycle_mem_rd", 128'(m_rd), 128'(0));
    tick();
    check("alloc_rd_wr", 128'({m_rd, m_wr}), 128'(2'b10));
    check("alloc_addr", 128'(m_addr), 128'(28'h4));
    n = 0;
    while (!m_ready && n < 50) begin tick(); n++; end
    check("ready_delay", 128'(n), 128'(3));
    check("stall_in_ready_cycle", 128'(p_stall), 128'(1));
    tick();
    check("miss_rdata", 128'(p_rdata), 128'(32'hA));
    check("miss_unstall", 128'(p_stall), 128'(0));
    check("idle_mem_rd", 128'(m_rd), 128'(0));
    tick();
    p_rd = 1'b0;

    // Write hit then read-back next cycle
    wr0 = wr_cnt; rd0 = rd_cnt;
    access_a(1'b1, 30'h11, 32'h1234, q, cyc);
    check("wr_hit_stall_cycles", 128'(cyc), 128'(0));
    access_a(1'b0, 30'h11, '0, q, cyc);
    check("rd_after_wr", 128'(q), 128'(32'h1234));
    check("rd_after_wr_cycles", 128'(cyc), 128'(0));
    check("hit_no_mem_traffic", 128'(wr_cnt - wr0 + rd_cnt - rd0), 128'(0));

    // LRU victim with dirty write-back
    access_a(1'b0, 30'h20, '0, q, cyc);
    check("tag2_rdata", 128'(q), 128'(32'h80));
    check("tag2_miss_cycles", 128'(cyc), 128'(5));
    access_a(1'b0, 30'h20, '0, q, cyc);
    check("tag2_touch_cycles", 128'(cyc), 128'(0));
    wr0 = wr_cnt; rd0 = rd_cnt;
    access_a(1'b0, 30'h30, '0, q, cyc);
    check("tag3_rdata", 128'(q), 128'(32'hC0));
    check("tag3_dirty_miss_cycles", 128'(cyc), 128'(10));
    check("evict_wr_count", 128'(wr_cnt - wr0), 128'(1));
    check("evict_rd_count", 128'(rd_cnt - rd0), 128'(1));
    check("evict_wb_addr", 128'(wq_addr[wq_addr.size()-1]), 128'(28'h4));
    check("evict_wb_data", wq_data[wq_data.size()-1], {32'hD, 32'hC, 32'h1234, 32'hA});
    check("wb_before_alloc", 128'(wr_seq < rd_seq), 128'(1));
    access_a(1'b0, 30'h20, '0, q, cyc);
    check("tag2_still_resident", 128'(cyc), 128'(0));
    check("tag2_data", 128'(q), 128'(32'h80));

    // Flush three dirty lines
    access_a(1'b1, 30'h30, 32'h1111_0000, q, cyc);
    access_a(1'b1, 30'h14, 32'h2222_0000, q, cyc);
    access_a(1'b1, 30'h28, 32'h3333_0000, q, cyc);
    wq_addr.delete(); wq_data.delete();
    wr0 = wr_cnt; pulses = 0;
    p_flush = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (p_done) begin pulses++; p_flush = 1'b0; end
    end
    p_flush = 1'b0;
    check("flush_pulses", 128'(pulses), 128'(1));
    check("flush_wr_count", 128'(wq_addr.size()), 128'(3));
    check("flush_addr0", 128'(wq_addr[0]), 128'(28'hC));
    check("flush_addr1", 128'(wq_addr[1]), 128'(28'h5));
    check("flush_addr2", 128'(wq_addr[2]), 128'(28'hA));
    check("flush_data0", wq_data[0], put_word(dline(28'hC), 0, 32'h1111_0000));
    check("flush_data2", wq_data[2], put_word(dline(28'hA), 0, 32'h3333_0000));
    access_a(1'b0, 30'h40, '0, q, cyc);
    check("post_flush_rd40", 128'(q), 128'(32'h100));
    access_a(1'b0, 30'h50, '0, q, cyc);
    check("post_flush_rd50", 128'(q), 128'(32'h140));
    access_a(1'b0, 30'h30, '0, q, cyc);
    check("post_flush_rd30", 128'(q), 128'(32'h1111_0000));
    check("post_flush_no_wb", 128'(wr_cnt - wr0), 128'(3));

    // Reset during ALLOCATE
    lat_a = 20;
    p_addr = 30'h64; p_rd = 1'b1;
    n = 0;
    while (!m_rd && n < 10) begin tick(); n++; end
    check("alloc_entered", 128'(m_rd), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async_mem_rd", 128'(m_rd), 128'(0));
    check("rst_async_stall", 128'(p_stall), 128'(0));
    p_rd = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    lat_a = 3;
    tick();
    access_a(1'b0, 30'h64, '0, q, cyc);
    check("after_rst_miss_cycles", 128'(cyc), 128'(5));
    check("after_rst_rdata", 128'(q), 128'(32'h190));
    access_a(1'b0, 30'h11, '0, q, cyc);
    check("after_rst_rd11_cycles", 128'(cyc), 128'(5));
    check("after_rst_rd11", 128'(q), 128'(32'h1234));

    // Randomised run on the 4-way instance
    for (int i = 0; i < 300; i++) begin
      lat_b = $urandom_range(0, 2);
      a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        ref_mem[a] = d;
        access_b(1'b1, a, d, q);
      end else begin
        access_b(1'b0, a, '0, q);
        check("w4_rand_rd", 128'(q), 128'(ref_val(a)));
      end
    end
    pulses = 0;
    b_flush = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b_done) begin pulses++; b_flush = 1'b0; end
    end
    b_flush = 1'b0;
    check("w4_flush_pulses", 128'(pulses), 128'(1));
    for (int i = 0; i < 48; i++) begin
      for (int h = 0; h < 2; h++) begin
        a = 30'(i);
        a[29] = h[0];
        access_b(1'b0, a, '0, q);
        check("w4_sweep_rd", 128'(q), 128'(ref_val(a)));
      end
    end

    check("mem_rd_wr_exclusive", 128'(both_err), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
